// File: rtl/dmem_arb_pkg.sv
// Shared state encoding, default memory depth and the index-width helper for the
// data-memory arbiter.
package dmem_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int DEPTH_DEF = 128;

    // Address bits needed to index DEPTH words; never less than one bit.
    function automatic int idx_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/dmem_dma_ctr.sv
// DMA burst bookkeeping: current word index, beats remaining and the CPU-denial wait counter.
// Loaded at burst start, stepped on each granted beat, bumped (saturating) on each denied BURST cycle.
module dmem_dma_ctr
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int LEN_W    = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_load,
    input  logic                    i_step,
    input  logic                    i_deny,
    input  logic [idx_w(DEPTH)-1:0] i_base,
    input  logic [LEN_W-1:0]        i_len,
    output logic [idx_w(DEPTH)-1:0] o_cur_addr,
    output logic [LEN_W-1:0]        o_remain,
    output logic                    o_wait_sat
);

    localparam int AW = idx_w(DEPTH);
    localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [AW-1:0]    r_cur_addr;
    logic [LEN_W-1:0] r_remain;
    logic [WW-1:0]    r_wait_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cur_addr <= '0;
            r_remain   <= '0;
            r_wait_cnt <= '0;
        end else if (i_load) begin
            r_cur_addr <= i_base;
            r_remain   <= i_len;
            r_wait_cnt <= '0;
        end else if (i_step) begin
            // Explicit wrap so non-power-of-two depths still index legally.
            r_cur_addr <= (r_cur_addr == LAST) ? '0 : r_cur_addr + 1'b1;
            r_remain   <= r_remain - 1'b1;
            r_wait_cnt <= '0;
        end else if (i_deny && (r_wait_cnt < WMAX)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign o_cur_addr = r_cur_addr;
    assign o_remain   = r_remain;
    assign o_wait_sat = (r_wait_cnt >= WMAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the MEM stage (priority) and a burst DMA engine;
// the CPU sees 0 wait states unless the DMA has been denied MAX_WAIT cycles, which forces a stalled beat.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int MAX_WAIT = 4,
    parameter int LEN_W    = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             CpuReq,
    input  logic             CpuWE,
    input  logic [31:0]      CpuAddr,
    input  logic [31:0]      CpuWD,
    output logic [31:0]      CpuRD,
    output logic             CpuStall,
    input  logic             DmaStart,
    input  logic             DmaWE,
    input  logic [31:0]      DmaBase,
    input  logic [LEN_W-1:0] DmaLen,
    input  logic [31:0]      DmaWD,
    output logic [31:0]      DmaRD,
    output logic             DmaBeat,
    output logic             DmaBusy,
    output logic             DmaDone,
    output logic [31:0]      MemAddr,
    output logic             MemWE,
    output logic [31:0]      MemWD,
    input  logic [31:0]      MemRD
);

    localparam int AW = idx_w(DEPTH);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_dir_we;
    logic             w_load;
    logic             w_grant;
    logic             w_deny;
    logic             w_wait_sat;
    logic [AW-1:0]    w_cur_addr;
    logic [AW-1:0]    w_cpu_idx;
    logic [AW-1:0]    w_base_idx;
    logic [LEN_W-1:0] w_remain;

    assign w_cpu_idx  = AW'(CpuAddr % 32'(DEPTH));
    assign w_base_idx = AW'(DmaBase % 32'(DEPTH));

    assign w_load  = !Reset && (r_state == ST_IDLE) && DmaStart;
    assign w_grant = !Reset && (r_state == ST_BURST) && (!CpuReq || w_wait_sat);
    assign w_deny  = !Reset && (r_state == ST_BURST) && !w_grant;

    dmem_dma_ctr #(
        .DEPTH    (DEPTH),
        .LEN_W    (LEN_W),
        .MAX_WAIT (MAX_WAIT)
    ) u_ctr (
        .i_clk      (CLK),
        .i_rst      (Reset),
        .i_load     (w_load),
        .i_step     (w_grant),
        .i_deny     (w_deny),
        .i_base     (w_base_idx),
        .i_len      (DmaLen),
        .o_cur_addr (w_cur_addr),
        .o_remain   (w_remain),
        .o_wait_sat (w_wait_sat)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state  <= ST_IDLE;
            r_dir_we <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) r_dir_we <= DmaWE;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (DmaStart) w_state_nxt = (DmaLen != '0) ? ST_BURST : ST_DONE;
            ST_BURST: if (w_grant && (w_remain == LEN_W'(1))) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // The CPU owns the port by default; a DMA grant overrides the whole memory bus.
    always_comb begin
        MemAddr  = {{(32-AW){1'b0}}, w_cpu_idx};
        MemWE    = !Reset && CpuReq && CpuWE;
        MemWD    = CpuWD;
        DmaBeat  = 1'b0;
        CpuStall = 1'b0;
        if (w_grant) begin
            MemAddr  = {{(32-AW){1'b0}}, w_cur_addr};
            MemWE    = r_dir_we;
            MemWD    = DmaWD;
            DmaBeat  = 1'b1;
            CpuStall = CpuReq;
        end
        DmaBusy = !Reset && ((r_state == ST_BURST) || (r_state == ST_DONE));
        DmaDone = !Reset && (r_state == ST_DONE);
    end

    assign CpuRD = MemRD;
    assign DmaRD = MemRD;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table for single-cycle behaviour plus
// hand sequences for reset and CPU-starvation of the DMA.
module tb_dmem_arbiter;

    logic        CLK = 1'b0;
    logic        Reset, CpuReq, CpuWE, CpuStall;
    logic [31:0] CpuAddr, CpuWD, CpuRD;
    logic        DmaStart, DmaWE, DmaBeat, DmaBusy, DmaDone;
    logic [31:0] DmaBase, DmaWD, DmaRD;
    logic [7:0]  DmaLen;
    logic [31:0] MemAddr, MemWD, MemRD;
    logic        MemWE;

    logic [31:0] mem [0:127];
    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (MemWE) mem[MemAddr[6:0]] <= MemWD;
    assign MemRD = mem[MemAddr[6:0]];

    dmem_arbiter #(.DEPTH(128), .MAX_WAIT(4), .LEN_W(8)) dut (
        .CLK(CLK), .Reset(Reset), .CpuReq(CpuReq), .CpuWE(CpuWE), .CpuAddr(CpuAddr),
        .CpuWD(CpuWD), .CpuRD(CpuRD), .CpuStall(CpuStall), .DmaStart(DmaStart),
        .DmaWE(DmaWE), .DmaBase(DmaBase), .DmaLen(DmaLen), .DmaWD(DmaWD), .DmaRD(DmaRD),
        .DmaBeat(DmaBeat), .DmaBusy(DmaBusy), .DmaDone(DmaDone), .MemAddr(MemAddr),
        .MemWE(MemWE), .MemWD(MemWD), .MemRD(MemRD)
    );

    typedef struct {
        logic [31:0] rst, cr, cw, ca, cwd, st, dwe, base, len, dwd;
        logic [31:0] es, eb, ebusy, ed, ewe, ea, crd, erd;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input logic [31:0] rst, cr, cw, ca, cwd, st, dwe, base, len, dwd,
                     input logic [31:0] es, eb, ebusy, ed, ewe, ea, crd, erd);
        vec_t t;
        t.rst = rst; t.cr = cr; t.cw = cw; t.ca = ca; t.cwd = cwd;
        t.st = st; t.dwe = dwe; t.base = base; t.len = len; t.dwd = dwd;
        t.es = es; t.eb = eb; t.ebusy = ebusy; t.ed = ed; t.ewe = ewe; t.ea = ea;
        t.crd = crd; t.erd = erd;
        tbl.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        Reset = 1'b0; CpuReq = 1'b0; CpuWE = 1'b0; CpuAddr = '0; CpuWD = '0;
        DmaStart = 1'b0; DmaWE = 1'b0; DmaBase = '0; DmaLen = '0; DmaWD = '0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = '0;
        drive_idle();

        // Reset with CPU and DMA both pushing: nothing may reach memory or start.
        Reset = 1'b1; CpuReq = 1'b1; CpuWE = 1'b1; CpuAddr = 9; CpuWD = 32'hBAD;
        DmaStart = 1'b1; DmaLen = 3; DmaWE = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK); #1;
            chk($sformatf("rst%0d_memwe", c), 32'(MemWE), 0);
            chk($sformatf("rst%0d_stall", c), 32'(CpuStall), 0);
            chk($sformatf("rst%0d_beat", c), 32'(DmaBeat), 0);
            chk($sformatf("rst%0d_busy", c), 32'(DmaBusy), 0);
            chk($sformatf("rst%0d_done", c), 32'(DmaDone), 0);
        end
        @(negedge CLK); drive_idle(); #1;
        chk("post_rst_busy", 32'(DmaBusy), 0);
        chk("post_rst_memwe", 32'(MemWE), 0);
        chk("post_rst_mem9", mem[9], 0);

        //  rst cr cw ca cwd             st dwe base len dwd   es eb busy ed we ea    crd erd
        v(0, 1, 1, 5, 32'hDEADBEEF,  0, 0, 0, 0, 0,        0, 0, 0, 0, 1, 5,     0, 0);
        v(0, 1, 0, 5, 0,             0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 5,     1, 32'hDEADBEEF);
        v(0, 1, 0, 133, 0,           0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 5,     1, 32'hDEADBEEF);
        // DMA write burst 10..13 <= 1..4, CPU idle
        v(0, 0, 0, 0, 0,             1, 1, 10, 4, 0,       0, 0, 0, 0, 0, 0,     0, 0);
        for (int k = 1; k <= 4; k++)
            v(0, 0, 0, 0, 0,         0, 0, 0, 0, k,        0, 1, 1, 0, 1, 9 + k, 0, 0);
        v(0, 0, 0, 0, 0,             0, 0, 0, 0, 0,        0, 0, 1, 1, 0, 0,     0, 0);
        v(0, 0, 0, 0, 0,             0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0,     0, 0);
        for (int k = 1; k <= 4; k++)
            v(0, 1, 0, 9 + k, 0,     0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 9 + k, 1, k);
        // Wrapping read burst from 126; start coincides with a CPU write that wins
        v(0, 1, 1, 7, 32'h1234,      1, 0, 126, 4, 0,      0, 0, 0, 0, 1, 7,     0, 0);
        v(0, 0, 0, 0, 0,             0, 0, 0, 0, 0,        0, 1, 1, 0, 0, 126,   0, 0);
        v(0, 0, 0, 0, 0,             0, 0, 0, 0, 0,        0, 1, 1, 0, 0, 127,   0, 0);
        v(0, 0, 0, 0, 0,             0, 0, 0, 0, 0,        0, 1, 1, 0, 0, 0,     0, 0);
        v(0, 0, 0, 0, 0,             0, 0, 0, 0, 0,        0, 1, 1, 0, 0, 1,     0, 0);
        v(0, 0, 0, 0, 0,             0, 0, 0, 0, 0,        0, 0, 1, 1, 0, 0,     0, 0);
        v(0, 1, 0, 7, 0,             0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 7,     1, 32'h1234);
        // Zero-length burst: straight to DONE, no memory write
        v(0, 0, 0, 0, 0,             1, 1, 3, 0, 0,        0, 0, 0, 0, 0, 0,     0, 0);
        v(0, 0, 0, 0, 0,             0, 0, 0, 0, 32'h99,   0, 0, 1, 1, 0, 0,     0, 0);
        v(0, 0, 0, 0, 0,             0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0,     0, 0);
        // DmaStart mid-burst is ignored
        v(0, 0, 0, 0, 0,             1, 1, 40, 3, 0,       0, 0, 0, 0, 0, 0,     0, 0);
        v(0, 0, 0, 0, 0,             1, 0, 50, 9, 5,       0, 1, 1, 0, 1, 40,    0, 0);
        v(0, 0, 0, 0, 0,             0, 0, 0, 0, 6,        0, 1, 1, 0, 1, 41,    0, 0);
        v(0, 0, 0, 0, 0,             0, 0, 0, 0, 7,        0, 1, 1, 0, 1, 42,    0, 0);
        v(0, 0, 0, 0, 0,             0, 0, 0, 0, 0,        0, 0, 1, 1, 0, 0,     0, 0);
        v(0, 0, 0, 0, 0,             0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0,     0, 0);
        v(0, 1, 0, 41, 0,            0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 41,    1, 6);
        v(0, 1, 0, 50, 0,            0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 50,    1, 0);
        // Reset after beat 2 of a 6-beat write burst, then a fresh burst
        v(0, 0, 0, 0, 0,             1, 1, 20, 6, 0,       0, 0, 0, 0, 0, 0,     0, 0);
        v(0, 0, 0, 0, 0,             0, 0, 0, 0, 32'hA1,   0, 1, 1, 0, 1, 20,    0, 0);
        v(0, 0, 0, 0, 0,             0, 0, 0, 0, 32'hA2,   0, 1, 1, 0, 1, 21,    0, 0);
        v(1, 0, 0, 0, 0,             0, 0, 0, 0, 32'hA3,   0, 0, 0, 0, 0, 0,     0, 0);
        v(0, 0, 0, 0, 0,             0, 0, 0, 0, 32'hA4,   0, 0, 0, 0, 0, 0,     0, 0);
        v(0, 0, 0, 0, 0,             0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0,     0, 0);
        v(0, 1, 0, 22, 0,            0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 22,    1, 0);
        v(0, 1, 0, 21, 0,            0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 21,    1, 32'hA2);
        v(0, 0, 0, 0, 0,             1, 1, 30, 1, 0,       0, 0, 0, 0, 0, 0,     0, 0);
        v(0, 0, 0, 0, 0,             0, 0, 0, 0, 32'h77,   0, 1, 1, 0, 1, 30,    0, 0);
        v(0, 0, 0, 0, 0,             0, 0, 0, 0, 0,        0, 0, 1, 1, 0, 0,     0, 0);
        v(0, 1, 0, 30, 0,            0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 30,    1, 32'h77);

        foreach (tbl[i]) begin
            @(negedge CLK);
            Reset = tbl[i].rst[0]; CpuReq = tbl[i].cr[0]; CpuWE = tbl[i].cw[0];
            CpuAddr = tbl[i].ca; CpuWD = tbl[i].cwd; DmaStart = tbl[i].st[0];
            DmaWE = tbl[i].dwe[0]; DmaBase = tbl[i].base; DmaLen = tbl[i].len[7:0];
            DmaWD = tbl[i].dwd;
            #1;
            chk($sformatf("v%0d_stall", i), 32'(CpuStall), tbl[i].es);
            chk($sformatf("v%0d_beat", i), 32'(DmaBeat), tbl[i].eb);
            chk($sformatf("v%0d_busy", i), 32'(DmaBusy), tbl[i].ebusy);
            chk($sformatf("v%0d_done", i), 32'(DmaDone), tbl[i].ed);
            chk($sformatf("v%0d_memwe", i), 32'(MemWE), tbl[i].ewe);
            chk($sformatf("v%0d_memaddr", i), MemAddr, tbl[i].ea);
            if (tbl[i].crd[0]) chk($sformatf("v%0d_cpurd", i), CpuRD, tbl[i].erd);
        end

        // Starvation: CPU reads every cycle; a 2-beat burst must still get a beat every 5th cycle.
        @(negedge CLK);
        drive_idle();
        CpuReq = 1'b1; CpuAddr = 3;
        DmaStart = 1'b1; DmaWE = 1'b1; DmaBase = 60; DmaLen = 2; DmaWD = 32'h55;
        #1;
        chk("starve_start_beat", 32'(DmaBeat), 0);
        chk("starve_start_stall", 32'(CpuStall), 0);
        for (int c = 1; c <= 12; c++) begin
            @(negedge CLK);
            DmaStart = 1'b0;
            #1;
            chk($sformatf("starve_c%0d_beat", c), 32'(DmaBeat), 32'(c == 5 || c == 10));
            chk($sformatf("starve_c%0d_stall", c), 32'(CpuStall), 32'(c == 5 || c == 10));
            chk($sformatf("starve_c%0d_done", c), 32'(DmaDone), 32'(c == 11));
            chk($sformatf("starve_c%0d_busy", c), 32'(DmaBusy), 32'(c <= 11));
        end
        chk("starve_mem60", mem[60], 32'h55);
        chk("starve_mem61", mem[61], 32'h55);
        chk("starve_mem62", mem[62], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
